// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 scan code to ASCII decoder with 8-entry show-ahead FIFO
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [7:0]        key_ascii,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              shift_active,
    output logic              caps_lock,
    output logic              overflow,
    output logic [ADDR_W:0]   fifo_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(FIFO_DEPTH);

    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
        8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    localparam logic [7:0] DIGIT_PLAIN [10] = '{
        8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30};
    localparam logic [7:0] DIGIT_SHIFT [10] = '{
        8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29};

    // Returns {mapped, ascii}; letters follow shift^caps, digits follow shift only.
    function automatic logic [8:0] xlate(input logic [7:0] code, input logic shift, input logic caps);
        logic [8:0] r;
        r = 9'h000;
        for (int i = 0; i < 26; i++)
            if (code == LETTER_CODES[i])
                r = {1'b1, ((shift ^ caps) ? 8'h41 : 8'h61) + 8'(i)};
        for (int i = 0; i < 10; i++)
            if (code == DIGIT_CODES[i])
                r = {1'b1, shift ? DIGIT_SHIFT[i] : DIGIT_PLAIN[i]};
        case (code)
            8'h29:   r = {1'b1, 8'h20};
            8'h5A:   r = {1'b1, 8'h0D};
            8'h66:   r = {1'b1, 8'h08};
            8'h0D:   r = {1'b1, 8'h09};
            8'h76:   r = {1'b1, 8'h1B};
            default: ;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              lshift_q, lshift_d, rshift_q, rshift_d;
    logic              caps_q, caps_d, held_q, held_d;
    logic              overflow_q;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [8:0]        xl;
    logic              push_req, do_push, do_pop, full;
    logic [7:0]        push_char;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == 8'hF0)      state_d = ST_BRK;
                    else if (byte_in == 8'hE0) state_d = ST_EXT;
                end
                ST_EXT:  state_d = (byte_in == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        push_req  = 1'b0;
        push_char = 8'h00;
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
        caps_d    = caps_q;
        held_d    = held_q;
        xl        = xlate(byte_in, lshift_q | rshift_q, caps_q);
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    case (byte_in)
                        8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF: ;
                        8'h12: lshift_d = 1'b1;
                        8'h59: rshift_d = 1'b1;
                        // caps_held blocks typematic repeats from re-toggling
                        8'h58: if (!held_q) begin
                            caps_d = ~caps_q;
                            held_d = 1'b1;
                        end
                        default: begin
                            push_req  = xl[8];
                            push_char = xl[7:0];
                        end
                    endcase
                end
                ST_BRK: begin
                    case (byte_in)
                        8'h12:   lshift_d = 1'b0;
                        8'h59:   rshift_d = 1'b0;
                        8'h58:   held_d   = 1'b0;
                        default: ;
                    endcase
                end
                ST_EXT: begin
                    if (byte_in == 8'h5A) begin
                        push_req  = 1'b1;
                        push_char = 8'h0D;
                    end else if (byte_in == 8'h4A) begin
                        push_req  = 1'b1;
                        push_char = 8'h2F;
                    end
                end
                default: ;
            endcase
        end
    end

    assign full    = (count_q == FULL_COUNT);
    assign do_pop  = key_valid & key_ready;
    assign do_push = push_req & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            caps_q     <= 1'b0;
            held_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            caps_q   <= caps_d;
            held_q   <= held_d;
            if (push_req & full & ~do_pop) overflow_q <= 1'b1;
            if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            if (do_push & ~do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop & ~do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_char;
    end

    assign key_valid    = (count_q != '0);
    assign key_ascii    = key_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign shift_active = lshift_q | rshift_q;
    assign caps_lock    = caps_q;
    assign overflow     = overflow_q;
    assign fifo_count   = count_q;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the raw PS/2 Set-2 byte stream from the keyboard scan stage and turns it into ASCII characters in an 8-entry show-ahead FIFO with a valid/ready handshake. It tracks make/break (F0) and extended (E0) prefixes, Shift and Caps Lock state, and drops keys with no ASCII mapping. It sits between the PS/2 receiver and the character display/terminal logic.

## Interface
- FIFO_DEPTH, 8, number of FIFO entries; power of two, at least 2
- ADDR_W, 3, log2(FIFO_DEPTH)
- clk  input  1  system clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- byte_in  input  8  received PS/2 byte; sampled only when byte_valid=1
- byte_valid  input  1  one-cycle strobe per received byte
- key_ascii  output  8  FIFO head character; 8'h00 when FIFO empty
- key_valid  output  1  FIFO non-empty
- key_ready  input  1  consumer accepts head when key_valid=1
- shift_active  output  1  either Shift key held
- caps_lock  output  1  Caps Lock toggle state
- overflow  output  1  sticky: a character was dropped because FIFO full
- fifo_count  output  ADDR_W+1  number of stored characters

## Operation
- Reset: FSM=IDLE, FIFO empty, fifo_count=0, key_valid=0, key_ascii=8'h00, shift_active=0, caps_lock=0, caps_held=0, overflow=0. Reset dominates all other inputs in the same cycle.
- Prefix FSM advances only on byte_valid. States:
  - IDLE: F0 -> BRK; E0 -> EXT; AA, FA, EE, FC, 00, FF -> ignored, stay IDLE; 12h or 59h -> set left/right shift flag; 58h -> if caps_held=0, toggle caps_lock and set caps_held (typematic repeats do not re-toggle); any other byte -> translate, push if mapped.
  - BRK: any byte -> clear matching shift flag (12h left, 59h right), or clear caps_held for 58h; no push; -> IDLE.
  - EXT: F0 -> EXT_BRK; 5Ah (keypad Enter) -> push 0Dh; 4Ah (keypad /) -> push 2Fh; other bytes dropped; -> IDLE.
  - EXT_BRK: any byte consumed, no push -> IDLE.
- shift_active = left_shift | right_shift.
- Translation:
  - Letters a-z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A. Uppercase when shift_active XOR caps_lock, else lowercase.
  - Digits 1-9,0: 16 1E 26 25 2E 36 3D 3E 46 45. Unshifted give '1'..'9','0'. Shifted give ! @ # $ % ^ & * ( ). Caps Lock does not affect digits.
  - Space 29h -> 20h; Enter 5Ah -> 0Dh; Backspace 66h -> 08h; Tab 0Dh -> 09h; Esc 76h -> 1Bh.
  - All other codes are unmapped: no push, no error.
- Translation uses shift/caps state as it stood before the current byte.
- FIFO behaviour:
  - Push on mapped make code. Pop when key_valid & key_ready.
  - Push while full with no same-cycle pop: the character is dropped and overflow is set. overflow clears only on rst.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the pop is a no-op because key_valid=0; the push is stored.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Byte strobed in cycle N: FSM, shift/caps and FIFO are updated at the clock edge ending cycle N. key_valid and fifo_count reflect the push from cycle N+1. Latency is 1 cycle.
- key_ascii is driven combinationally from the head entry and is stable while key_valid=1 and key_ready=0.
- Pop at the edge ending cycle M: the next head appears, or key_valid drops, in cycle M+1.
- Back-to-back byte_valid every cycle must be accepted without loss.
- key_ready may be held high permanently; the FIFO then drains one entry per cycle.

## Test plan
- Reset, then send 1Ch -> in the next cycle key_valid=1, key_ascii=61h ('a'), fifo_count=1. Pulse key_ready -> key_valid=0, key_ascii=00h.
- Send 12h, 1Ch, F0 12h, 1Ch -> FIFO holds 41h then 61h, and shift_active ends at 0. Send 12h, 16h -> 21h ('!').
- Send 58h, 58h, 58h (typematic), F0 58h, 1Ch -> caps_lock=1 with a single toggle, output 41h. Then 12h, 1Ch -> 61h.
- Send E0 5Ah -> 0Dh; E0 75h -> nothing; E0 F0 5Ah -> nothing; AA, FA -> nothing; final fifo_count=1.
- With key_ready=0, send 9 mapped make codes -> fifo_count=8 and overflow=1, and the head is the first character. On the 10th byte with key_ready=1 at full, count stays 8 and the new character lands at the tail.
- Assert rst mid-stream after F0 with shift held -> all outputs return to reset values. The next 1Ch produces 61h, not treated as a break.
